// File: rtl/fps_pkg.sv
// Shared types and defaults for the fp_cmd_sequencer slice.
package fps_pkg;

  localparam int NREGS_DEF  = 8;
  localparam int REG_AW_DEF = 3;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_READ = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Operand bundle presented to the addsub unit for one operation.
  typedef struct packed {
    logic        mode;
    logic [31:0] op1;
    logic [31:0] op2;
  } add_req_t;

endpackage

// File: rtl/fps_regfile.sv
// Operand register file: two combinational read ports, one write port.
module fps_regfile
  import fps_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [31:0]       rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [31:0]       rdata_b
);

  logic [NREGS-1:0][31:0] mem_q, mem_d;

  // Next contents: only the addressed entry changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage, cleared by reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/fp_cmd_sequencer.sv
// Command front-end for the single-precision addsub unit.
// Optional watchdog in WAIT enabled by defining FPS_TIMEOUT_EN.
module fp_cmd_sequencer
  import fps_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int REG_AW = REG_AW_DEF
`ifdef FPS_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_dst,
  input  logic [REG_AW-1:0] cmd_src1,
  input  logic [REG_AW-1:0] cmd_src2,
  input  logic [31:0]       cmd_imm,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              add_start,
  output logic              mode,
  output logic [31:0]       op1,
  output logic [31:0]       op2,
  input  logic [31:0]       add_result,
  input  logic              add_done,
  input  logic              add_overflow,
  output logic              busy,
  output logic              ovf_sticky,
  input  logic              clr_status,
  output logic              err_timeout
);

  state_e            state_q, state_d;
  add_req_t          req_q, req_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [31:0]       rf_wdata;
  logic [31:0]       rf_rdata_a, rf_rdata_b;
  op_e               op;

`ifdef FPS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  assign op = op_e'(cmd_op);

  fps_regfile #(
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk     (clk),
    .n_rst   (n_rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (cmd_src1),
    .rdata_a (rf_rdata_a),
    .raddr_b (cmd_src2),
    .rdata_b (rf_rdata_b)
  );

  // Next-state, operand latching, register writes and status updates.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    dst_d      = dst_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    rf_we      = 1'b0;
    rf_waddr   = cmd_dst;
    rf_wdata   = cmd_imm;
`ifdef FPS_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    err_d      = err_q;
    if (clr_status) err_d = 1'b0;
`endif
    // Clear first so a same-cycle overflow completion sets it again.
    if (clr_status) ovf_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (op)
            OP_LOAD: rf_we = 1'b1;
            OP_READ: begin
              rd_data_d  = rf_rdata_a;
              rd_valid_d = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              // Operands captured now, so src == dst is harmless.
              req_d.op1  = rf_rdata_a;
              req_d.op2  = rf_rdata_b;
              req_d.mode = (op == OP_SUB) ? MODE_SUB : MODE_ADD;
              dst_d      = cmd_dst;
              state_d    = ISSUE;
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef FPS_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (add_done) begin
          rf_we    = 1'b1;
          rf_waddr = dst_q;
          rf_wdata = add_result;
          if (add_overflow) ovf_d = 1'b1;
          state_d  = IDLE;
        end
`ifdef FPS_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Unit never answered: abandon without writeback.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      dst_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      dst_q      <= dst_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef FPS_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign add_start  = (state_q == ISSUE);
  assign mode       = req_q.mode;
  assign op1        = req_q.op1;
  assign op2        = req_q.op2;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign ovf_sticky = ovf_q;

endmodule
